pid_pwm_out: RTL
================

# pid_pwm_out

Output stage downstream of the PID controller. It accepts the controller's signed Q-format command, clamps it, slew-limits it and maps it to a PWM duty cycle. It drives a complementary pwm_hi/pwm_lo pair with dead time. Once per PWM period it pulses `tick`, which drives the PID's `iterate_enable`, so the control loop runs at the PWM rate.

## Interface
- D_WIDTH, 16, command width (signed, matches PID `out`)
- SPAN_LOG2, 13, command range is [-2^(SPAN_LOG2-1), +2^(SPAN_LOG2-1)] (±4096 by default)
- CNT_WIDTH, 10, PWM counter / period / duty width
- DEAD_CYCLES, 4, dead-time length in clk cycles (≥1)
- clk  input  1  clock
- rstb  input  1  reset, asynchronous, active-low
- enable  input  1  run PWM; low forces IDLE
- period  input  CNT_WIDTH  PWM period in cycles; values <2 force IDLE
- slew_max  input  D_WIDTH  max |change| of applied command per period; 0 means unlimited
- cmd  input  D_WIDTH signed  command from PID `out`
- cmd_valid  input  1  one-cycle qualifier, from PID `out_valid`
- tick  output  1  one-cycle pulse at start of each period, to PID `iterate_enable`
- pwm_hi  output  1  high-side drive
- pwm_lo  output  1  low-side drive
- duty  output  CNT_WIDTH  duty currently in effect (0..period)
- sat_flag  output  1  last accepted cmd was clamped

## Operation
- Reset values: tick=0, pwm_hi=0, pwm_lo=0, duty=0, sat_flag=0. Internal: cnt=0, target=0, applied=0, dcnt=0, state=IDLE.
- State IDLE: cnt held at 0, dcnt=0, pwm_hi=pwm_lo=0, no tick. target and applied are retained.
- IDLE→RUN on the first cycle with enable=1 and period≥2. RUN→IDLE on any cycle with enable=0 or period<2, effective the next cycle.
- RUN: cnt counts 0..period-1 and wraps. Each entry into cnt=0, by IDLE→RUN or by wrap, is a "load":
  - t = clamp(cmd) if cmd_valid in that cycle, else target.
  - applied ← applied moved toward t by at most slew_max. slew_max=0 moves it fully.
  - duty ← ((applied_new + 2^(SPAN_LOG2-1)) × period) >> SPAN_LOG2, truncated, in range 0..period.
  - tick=1 for that one cycle.
- Outside loads, a cmd_valid writes target ← clamp(cmd) and sat_flag ← (cmd outside range). A cmd_valid in a load cycle does both as well.
- Clamp: cmd > 2^(S-1) → 2^(S-1); cmd < -2^(S-1) → -2^(S-1).
- Arithmetic: slew compare in D_WIDTH+1 signed bits. The product uses SPAN_LOG2+1+CNT_WIDTH bits. No overflow is allowed.
- Dead time:
  - raw = (cnt < duty).
  - dcnt resets to 0 when raw changes, otherwise saturates at DEAD_CYCLES.
  - pwm_hi = raw & (dcnt==DEAD_CYCLES); pwm_lo = !raw & (dcnt==DEAD_CYCLES).
  - pwm_hi and pwm_lo are never both 1.
  - A raw pulse shorter than DEAD_CYCLES produces no output pulse.
- duty=0: pwm_lo is continuous after dead time. duty=period: pwm_hi is continuous after dead time.

## Timing
- pwm_hi/pwm_lo/tick are registered and lag cnt by 1 cycle.
- A cmd accepted during period N takes effect at the load starting period N+1.
- A change to `period` mid-period is used at the next load. If cnt ≥ new period, cnt wraps at the next cycle.
- PID latency is 6 cycles, so its result lands within the same period for period ≥ 8.
- rstb asserted mid-period: all outputs go to reset values immediately and asynchronously. Restart begins at the IDLE→RUN load.

## Configuration
- PID_PWM_SLEW_EN defined: slew limiting as specified.
- PID_PWM_SLEW_EN undefined: applied ← t at every load, and slew_max is ignored (port retained).

## Test plan
- Reset, enable=1, period=100, no cmd → tick every 100 cycles; duty=50; pwm_hi high 46 cycles and pwm_lo high 46 cycles per period; never both high.
- cmd=5000 with cmd_valid, slew_max=0 → next load duty=100, sat_flag=1; then cmd=-4096 → duty=0, sat_flag=0, pwm_lo continuous.
- Slew enabled, slew_max=1024, applied=0, cmd=4096 → duty sequence over successive loads 62, 75, 87, 100.
- cmd_valid in the same cycle as a load with cmd=-4096 → that load uses the new cmd (duty=0 with slew_max=0).
- duty=2 with DEAD_CYCLES=4 → no pwm_hi pulse; pwm_lo low for only the 2+4 dead-affected cycles.
- rstb pulsed at cnt=37 → outputs 0 at once; after release, first tick on the first enabled cycle and duty=50.

Source files
------------

// File: rtl/pid_pwm_out_if.sv
// pid_pwm_out_if: command/iterate handshake between the PID controller and its PWM output stage.
//   cmd       : signed Q-format command from PID `out`
//   cmd_valid : one-cycle qualifier from PID `out_valid`
//   tick      : one-cycle period-start pulse back to PID `iterate_enable`
//   modport master = PID side, modport slave = PWM output stage
interface pid_pwm_out_if #(parameter int D_WIDTH = 16);
    logic signed [D_WIDTH-1:0] cmd;
    logic                      cmd_valid;
    logic                      tick;
    modport master (output cmd, output cmd_valid, input tick);
    modport slave  (input cmd, input cmd_valid, output tick);
endinterface

// File: rtl/pid_pwm_out.sv
// pid_pwm_out: clamps, slew-limits and maps a PID command to a complementary dead-timed PWM pair.
//   clk, rstb (async, active-low)
//   enable, period     : run control; period < 2 or enable low holds the block idle
//   slew_max           : max applied-command change per period (0 = unlimited)
//   pid (slave)        : cmd / cmd_valid in, tick out (one pulse per PWM period)
//   pwm_hi, pwm_lo     : complementary drives with DEAD_CYCLES dead time
//   duty, sat_flag     : duty in effect, last accepted cmd was clamped
//   Build option: define PID_PWM_SLEW_EN to enable slew limiting; otherwise slew_max is ignored.
module pid_pwm_out #(
    parameter int D_WIDTH     = 16,
    parameter int SPAN_LOG2   = 13,
    parameter int CNT_WIDTH   = 10,
    parameter int DEAD_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rstb,
    input  logic                 enable,
    input  logic [CNT_WIDTH-1:0] period,
    input  logic [D_WIDTH-1:0]   slew_max,
    pid_pwm_out_if.slave         pid,
    output logic                 pwm_hi,
    output logic                 pwm_lo,
    output logic [CNT_WIDTH-1:0] duty,
    output logic                 sat_flag
);
    localparam int PW = SPAN_LOG2 + 1 + CNT_WIDTH;
    localparam int DW = $clog2(DEAD_CYCLES + 1);
    localparam logic signed [D_WIDTH-1:0] POS = D_WIDTH'(2 ** (SPAN_LOG2 - 1));
    localparam logic signed [D_WIDTH-1:0] NEG = -POS;
    localparam logic [SPAN_LOG2:0] HALF_U = (SPAN_LOG2 + 1)'(2 ** (SPAN_LOG2 - 1));
    localparam logic [DW-1:0] DEAD = DW'(DEAD_CYCLES);

    typedef enum logic {IDLE, RUN} state_t;
    state_t state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d, duty_q, duty_d, duty_new;
    logic signed [D_WIDTH-1:0] target_q, target_d, applied_q, applied_d, applied_new, clamped, t;
    logic [SPAN_LOG2:0] off;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic sat_q, sat_d, tick_q, tick_d, hi_q, hi_d, lo_q, lo_d, raw_q, raw_d;
    logic raw, run_ok, load, over, under;
`ifdef PID_PWM_SLEW_EN
    logic signed [D_WIDTH:0] base, diff, slew;
`else
    logic unused_slew;
    assign unused_slew = ^slew_max;
`endif

    always_comb begin
        run_ok = enable && (period >= CNT_WIDTH'(2));
        // a load is every entry into cnt=0: leaving IDLE, or wrapping (also when period shrank below cnt)
        load = run_ok && (state_q == IDLE || cnt_q >= period - CNT_WIDTH'(1));
        state_d = run_ok ? RUN : IDLE;
        cnt_d = (!run_ok || load) ? '0 : cnt_q + 1'b1;
        over = pid.cmd > POS;
        under = pid.cmd < NEG;
        clamped = over ? POS : under ? NEG : pid.cmd;
        t = pid.cmd_valid ? clamped : target_q;
`ifdef PID_PWM_SLEW_EN
        base = (D_WIDTH + 1)'(applied_q);
        diff = (D_WIDTH + 1)'(t) - base;
        slew = $signed({1'b0, slew_max});
        applied_new = (slew_max == '0) ? t :
                      (diff > slew)    ? D_WIDTH'(base + slew) :
                      (diff < -slew)   ? D_WIDTH'(base - slew) : t;
`else
        applied_new = t;
`endif
        // offset into 0..2^SPAN_LOG2, then scale by period and drop the SPAN_LOG2 fraction bits
        off = (SPAN_LOG2 + 1)'(applied_new) + HALF_U;
        duty_new = CNT_WIDTH'((PW'(off) * PW'(period)) >> SPAN_LOG2);
        applied_d = load ? applied_new : applied_q;
        duty_d = load ? duty_new : duty_q;
        tick_d = load;
        target_d = pid.cmd_valid ? clamped : target_q;
        sat_d = pid.cmd_valid ? (over || under) : sat_q;
        raw = cnt_q < duty_q;
        raw_d = (state_q == RUN) && raw;
        dcnt_d = (state_q != RUN || raw != raw_q) ? '0 : (dcnt_q == DEAD) ? dcnt_q : dcnt_q + 1'b1;
        hi_d = (state_q == RUN) && raw && (dcnt_d == DEAD);
        lo_d = (state_q == RUN) && !raw && (dcnt_d == DEAD);
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            duty_q    <= '0;
            target_q  <= '0;
            applied_q <= '0;
            dcnt_q    <= '0;
            sat_q     <= 1'b0;
            tick_q    <= 1'b0;
            hi_q      <= 1'b0;
            lo_q      <= 1'b0;
            raw_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            duty_q    <= duty_d;
            target_q  <= target_d;
            applied_q <= applied_d;
            dcnt_q    <= dcnt_d;
            sat_q     <= sat_d;
            tick_q    <= tick_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            raw_q     <= raw_d;
        end
    end

    assign pid.tick = tick_q;
    assign pwm_hi   = hi_q;
    assign pwm_lo   = lo_q;
    assign duty     = duty_q;
    assign sat_flag = sat_q;
endmodule
